div_iter: RTL and testbench



---
 rtl/div_iter.sv | 110 +++++++++++
 tb/tb_div_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider returning {remainder, quotient}.
// Latency: 33 cycles from the sampled request to ready_o (2 for divide by zero).
// Backpressure: the requester holds start_i until ready_o; the result is held in END until start_i drops.
module div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] rem_q;   // partial remainder
   logic [31:0] dvd_q;   // dividend bits shift out of the top, quotient bits shift in at the bottom
   logic [31:0] dsr_q;   // divisor magnitude
   logic        neg_a;   // dividend was negative (signed mode only)
   logic        neg_b;   // divisor was negative (signed mode only)

   logic [32:0] shifted;
   logic [33:0] sub;
   logic        borrow;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // One restoring step plus the sign fix-up applied on the final step
   always_comb begin
      shifted  = {rem_q, dvd_q[31]};
      sub      = {1'b0, shifted} - {2'b00, dsr_q};
      borrow   = sub[33];
      // The remainder always stays below the divisor, so 32 bits suffice
      rem_next = borrow ? shifted[31:0] : sub[31:0];
      quo_next = {dvd_q[30:0], ~borrow};
      quo_fix  = (neg_a ^ neg_b) ? (~quo_next + 32'd1) : quo_next;
      rem_fix  = neg_a ? (~rem_next + 32'd1) : rem_next;
   end

   // Control FSM with registered result and ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 5'd0;
         rem_q    <= 32'd0;
         dvd_q    <= 32'd0;
         dsr_q    <= 32'd0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     state <= S_BYZERO;
                  end else begin
                     state <= S_ON;
                     cnt   <= 5'd0;
                     rem_q <= 32'd0;
                     neg_a <= signed_div_i & opdata1_i[31];
                     neg_b <= signed_div_i & opdata2_i[31];
                     dvd_q <= (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
                     dsr_q <= (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
                  end
               end
            end
            S_BYZERO: begin
               if (annul_i) begin
                  state <= S_IDLE;
               end else begin
                  state    <= S_END;
                  ready_o  <= 1'b1;
                  result_o <= 64'd0;
               end
            end
            S_ON: begin
               if (annul_i) begin
                  state <= S_IDLE;
               end else begin
                  rem_q <= rem_next;
                  dvd_q <= quo_next;
                  cnt   <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     state    <= S_END;
                     ready_o  <= 1'b1;
                     result_o <= {rem_fix, quo_fix};
                  end
               end
            end
            S_END: begin
               if (!start_i) begin
                  state    <= S_IDLE;
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed cases followed by randomized divides checked against plain arithmetic.
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks;
   int failures;

   div_iter dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {remainder, quotient} from ordinary integer division (truncating toward zero)
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Counts edges from the sampling edge until ready_o is seen (bounded)
   task automatic wait_ready(input int limit, output int k);
      k = limit + 1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
      int k;
      int lat;
      lat = (b == 32'd0) ? 2 : 33;
      @(negedge clk);
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = s;
      start_i      = 1'b1;
      @(posedge clk);
      #1;
      // Operand inputs must be ignored once the divide is under way
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~s;
      if (ready_o) k = 1;
      else begin
         wait_ready(40, k);
         k = k + 1;
      end
      check({tag, "_latency"}, 64'(k), 64'(lat));
      check({tag, "_result"}, result_o, exp);
      // Holding start keeps the result stable in END
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {ready_o, result_o}, {1'b1, exp});
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_release"}, {ready_o, result_o}, 65'd0);
   endtask

   initial begin
      int k;
      int seen;
      logic [31:0] ra, rb;
      logic        rs;
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      #1;
      check("reset_outputs", {ready_o, result_o}, 65'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_div("udiv_100_7",  32'd100,        32'd7,          1'b0, 64'h00000002_0000000E);
      run_div("sdiv_m7_2",   32'hFFFFFFF9,   32'h2,          1'b1, 64'hFFFFFFFF_FFFFFFFD);
      run_div("sdiv_7_m2",   32'h7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD);
      run_div("div_zero",    32'h1234,       32'h0,          1'b0, 64'h0);
      run_div("sdiv_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000);
      run_div("udiv_max_1",  32'hFFFFFFFF,   32'h1,          1'b0, 64'h00000000_FFFFFFFF);
      run_div("udiv_big",    32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'h00000000_00000001);

      // Annul mid-divide: no result ever appears
      @(negedge clk);
      opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
      repeat (10) @(posedge clk);          // E0..E9
      @(negedge clk);
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk);                      // E10 samples annul
      @(negedge clk);
      annul_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) seen = 1;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
      run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003);

      // start together with annul in IDLE does not start
      @(negedge clk);
      opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) seen = 1;
      end
      check("start_annul_idle", 64'(seen), 64'd0);

      // Async reset while the result is being presented clears outputs at once
      @(negedge clk);
      opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
      wait_ready(40, k);
      check("pre_reset_result", result_o, 64'h00000002_0000000E);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_end", {ready_o, result_o}, 65'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst = 1'b0;

      // Async reset at E15 of a divide
      @(negedge clk);
      opdata1_i = 32'h12345678; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (16) @(posedge clk);          // E0..E15
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_on", {ready_o, result_o}, 65'd0);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("reset_held", {ready_o, result_o}, 65'd0);
      @(negedge clk);
      rst = 1'b0;
      run_div("after_reset_50_8", 32'd50, 32'd8, 1'b0, 64'h00000002_00000006);

      // Randomized divides against the arithmetic reference
      for (int n = 0; n < 24; n++) begin
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       ra = 32'h80000000;
            1:       ra = $urandom_range(0, 255);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFFFFFF;
            2:       rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         run_div($sformatf("rand%0d", n), ra, rb, rs, model(ra, rb, rs));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
